flow_ctrl_unit: RTL and testbench

- Program-flow end of the ALU interface. It consumes the zero/sign/carry flags produced by the ALU circuits and owns the status register and program counter.
- Executes the program-flow instruction class: trap, no-op, unconditional and flag-conditional jumps, load status register, and XOR status register.
- Sits between the instruction issue stage (valid/ready op port) and fetch (pc/flush outputs).

---
 rtl/flow_pkg.sv | 52 +++++
 rtl/flow_pc_next.sv | 46 ++++
 rtl/flow_ctrl_unit.sv | 189 ++++++++++++++++++
 tb/tb_flow_ctrl_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_pkg.sv
// Shared definitions for the program-flow unit: op codes, FSM state encoding,
// status-register bit positions, trap causes and next-pc selector codes.
package flow_pkg;

   localparam logic [3:0] OP_TRAP = 4'd0;
   localparam logic [3:0] OP_NOP  = 4'd1;
   localparam logic [3:0] OP_JMP  = 4'd2;
   localparam logic [3:0] OP_JZ   = 4'd3;
   localparam logic [3:0] OP_JS   = 4'd4;
   localparam logic [3:0] OP_JZS  = 4'd5;
   localparam logic [3:0] OP_LSR  = 4'd6;
   localparam logic [3:0] OP_XSR  = 4'd7;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_TRAP  = 2'd2;

   localparam int SR_Z = 0;
   localparam int SR_S = 1;
   localparam int SR_C = 2;
   localparam int SR_T = 3;

   localparam logic [1:0] CAUSE_TRAP    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;

   localparam logic [1:0] PC_HOLD = 2'd0;
   localparam logic [1:0] PC_INC  = 2'd1;
   localparam logic [1:0] PC_JMP  = 2'd2;
   localparam logic [1:0] PC_VEC  = 2'd3;

   // Ops that read or overwrite flags must wait until every in-flight ALU result has landed.
   function automatic logic needs_flags(input logic [3:0] op);
      logic r;
      case (op)
         OP_JZ, OP_JS, OP_JZS, OP_LSR, OP_XSR: r = 1'b1;
         default:                              r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic jump_taken(input logic [3:0] op, input logic [3:0] sr);
      logic r;
      case (op)
         OP_JZ:   r = sr[SR_Z];
         OP_JS:   r = sr[SR_S];
         OP_JZS:  r = sr[SR_Z] | sr[SR_S];
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/flow_pc_next.sv
// Combinational next-pc selection: hold, sequential increment, jump target or
// trap vector, with half-word mode confining the pc to the low half.
module flow_pc_next
   import flow_pkg::*;
#(
   parameter int                ADDR_W   = 20,
   parameter logic [ADDR_W-1:0] TRAP_VEC = 20'h00010
) (
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [ADDR_W-1:0] target_i,
   input  logic              mode_i,
   input  logic [1:0]        sel_i,
   output logic [ADDR_W-1:0] pc_next_o
);

   localparam int HALF_W = ADDR_W / 2;

   logic [HALF_W-1:0] half_inc_s;

   assign half_inc_s = pc_i[HALF_W-1:0] + HALF_W'(1);

   // Half-word mode wraps within the low half and forces the upper half to zero.
   always_comb begin
      pc_next_o = pc_i;
      case (sel_i)
         PC_HOLD: pc_next_o = pc_i;
         PC_INC: begin
            if (mode_i) begin
               pc_next_o = pc_i + ADDR_W'(1);
            end else begin
               pc_next_o = {{(ADDR_W-HALF_W){1'b0}}, half_inc_s};
            end
         end
         PC_JMP: begin
            if (mode_i) begin
               pc_next_o = target_i;
            end else begin
               pc_next_o = {{(ADDR_W-HALF_W){1'b0}}, target_i[HALF_W-1:0]};
            end
         end
         PC_VEC:  pc_next_o = TRAP_VEC;
         default: pc_next_o = pc_i;
      endcase
   end

endmodule

// File: rtl/flow_ctrl_unit.sv
// Program-flow unit: owns pc and status register, executes flow ops, tracks
// in-flight ALU ops and handles trap entry/acknowledge.
module flow_ctrl_unit
   import flow_pkg::*;
#(
   parameter int                ADDR_W   = 20,
   parameter logic [ADDR_W-1:0] RESET_PC = 20'h00000,
   parameter logic [ADDR_W-1:0] TRAP_VEC = 20'h00010,
   parameter int                PEND_MAX = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [3:0]        op_code,
   input  logic              mode,
   input  logic [ADDR_W-1:0] target,
   input  logic [3:0]        imm_sr,
   input  logic              alu_issue,
   output logic              alu_issue_ready,
   input  logic              alu_flag_valid,
   input  logic              alu_zero,
   input  logic              alu_sign,
   input  logic              alu_carry,
   output logic [ADDR_W-1:0] pc,
   output logic [3:0]        status,
   output logic              flush,
   output logic              trap,
   input  logic              trap_ack,
   output logic [ADDR_W-1:0] epc,
   output logic [1:0]        trap_cause
);

   localparam int                PEND_W     = $clog2(PEND_MAX + 1);
   localparam logic [PEND_W-1:0] PEND_MAX_C = PEND_W'(PEND_MAX);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [3:0]        status_q, status_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic [1:0]        cause_q, cause_d;
   logic [PEND_W-1:0] pend_q, pend_d;

   logic       accept_s;
   logic       op_ready_s;
   logic       set_t_s;
   logic [1:0] pc_sel_s;

   assign op_ready_s = (state_q == ST_RUN) &&
                       (!needs_flags(op_code) || (pend_q == {PEND_W{1'b0}}));
   assign accept_s   = op_valid && op_ready_s;

   flow_pc_next #(
      .ADDR_W   (ADDR_W),
      .TRAP_VEC (TRAP_VEC)
   ) u_pc_next (
      .pc_i      (pc_q),
      .target_i  (target),
      .mode_i    (mode),
      .sel_i     (pc_sel_s),
      .pc_next_o (pc_d)
   );

   // Flow FSM: decodes accepted ops into pc selection, state change and trap capture.
   always_comb begin
      state_d  = state_q;
      pc_sel_s = PC_HOLD;
      epc_d    = epc_q;
      cause_d  = cause_q;
      set_t_s  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (accept_s) begin
               case (op_code)
                  OP_NOP, OP_LSR, OP_XSR: pc_sel_s = PC_INC;
                  OP_JMP: begin
                     pc_sel_s = PC_JMP;
                     state_d  = ST_FLUSH;
                  end
                  OP_JZ, OP_JS, OP_JZS: begin
                     if (jump_taken(op_code, status_q)) begin
                        pc_sel_s = PC_JMP;
                        state_d  = ST_FLUSH;
                     end else begin
                        pc_sel_s = PC_INC;
                     end
                  end
                  OP_TRAP: begin
                     epc_d   = pc_q;
                     cause_d = CAUSE_TRAP;
                     set_t_s = 1'b1;
                     state_d = ST_TRAP;
                  end
                  default: begin
                     epc_d   = pc_q;
                     cause_d = CAUSE_ILLEGAL;
                     set_t_s = 1'b1;
                     state_d = ST_TRAP;
                  end
               endcase
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: state_d = ST_RUN;
         ST_TRAP: begin
            if (trap_ack) begin
               pc_sel_s = PC_VEC;
               state_d  = ST_FLUSH;
            end else begin
               state_d = ST_TRAP;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Status register: ALU flags land first, then an accepted LSR/XSR or trap entry applies on top.
   always_comb begin
      status_d = status_q;
      if (alu_flag_valid) begin
         status_d[SR_Z] = alu_zero;
         status_d[SR_S] = alu_sign;
         status_d[SR_C] = alu_carry;
      end else begin
         status_d = status_q;
      end
      if (accept_s && (op_code == OP_LSR)) begin
         status_d = imm_sr;
      end else if (accept_s && (op_code == OP_XSR)) begin
         status_d = status_d ^ imm_sr;
      end else if (set_t_s) begin
         status_d[SR_T] = 1'b1;
      end else begin
         status_d = status_d;
      end
   end

   // In-flight ALU op counter; saturates at both ends.
   always_comb begin
      pend_d = pend_q;
      case ({alu_issue, alu_flag_valid})
         2'b10: begin
            if (pend_q < PEND_MAX_C) begin
               pend_d = pend_q + PEND_W'(1);
            end else begin
               pend_d = pend_q;
            end
         end
         2'b01: begin
            if (pend_q != {PEND_W{1'b0}}) begin
               pend_d = pend_q - PEND_W'(1);
            end else begin
               pend_d = pend_q;
            end
         end
         default: pend_d = pend_q;
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         status_q <= 4'b0000;
         epc_q    <= {ADDR_W{1'b0}};
         cause_q  <= CAUSE_TRAP;
         pend_q   <= {PEND_W{1'b0}};
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         status_q <= status_d;
         epc_q    <= epc_d;
         cause_q  <= cause_d;
         pend_q   <= pend_d;
      end
   end

   assign op_ready        = op_ready_s;
   assign alu_issue_ready = (pend_q < PEND_MAX_C);
   assign pc              = pc_q;
   assign status          = status_q;
   assign flush           = (state_q == ST_FLUSH);
   assign trap            = (state_q == ST_TRAP);
   assign epc             = epc_q;
   assign trap_cause      = cause_q;

endmodule

// File: tb/tb_flow_ctrl_unit.sv
// Self-checking bench for flow_ctrl_unit: directed scenarios followed by random
// traffic, all compared against an arithmetic reference model.
module tb_flow_ctrl_unit;

   logic        clk;
   logic        rst_n;
   logic        op_valid;
   logic        op_ready;
   logic [3:0]  op_code;
   logic        mode;
   logic [19:0] target;
   logic [3:0]  imm_sr;
   logic        alu_issue;
   logic        alu_issue_ready;
   logic        alu_flag_valid;
   logic        alu_zero;
   logic        alu_sign;
   logic        alu_carry;
   logic [19:0] pc;
   logic [3:0]  status;
   logic        flush;
   logic        trap;
   logic        trap_ack;
   logic [19:0] epc;
   logic [1:0]  trap_cause;

   int checks = 0;
   int errors = 0;

   // reference model state
   int       m_pc, m_epc, m_cause, m_pend;
   bit [3:0] m_sr;
   bit       m_flushing, m_trapped;

   flow_ctrl_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .op_valid        (op_valid),
      .op_ready        (op_ready),
      .op_code         (op_code),
      .mode            (mode),
      .target          (target),
      .imm_sr          (imm_sr),
      .alu_issue       (alu_issue),
      .alu_issue_ready (alu_issue_ready),
      .alu_flag_valid  (alu_flag_valid),
      .alu_zero        (alu_zero),
      .alu_sign        (alu_sign),
      .alu_carry       (alu_carry),
      .pc              (pc),
      .status          (status),
      .flush           (flush),
      .trap            (trap),
      .trap_ack        (trap_ack),
      .epc             (epc),
      .trap_cause      (trap_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_epc = 0; m_cause = 0; m_pend = 0;
      m_sr = 4'b0000; m_flushing = 1'b0; m_trapped = 1'b0;
   endtask

   function automatic bit model_ready();
      bit flag_op = (int'(op_code) >= 3) && (int'(op_code) <= 7);
      return !m_flushing && !m_trapped && (!flag_op || m_pend == 0);
   endfunction

   function automatic int seq_pc(int p, bit full);
      return full ? (p + 1) % (1 << 20) : ((p % 1024) + 1) % 1024;
   endfunction

   function automatic int jmp_pc(int t, bit full);
      return full ? t : t % 1024;
   endfunction

   // Advance the model by one clock using the current input values.
   task automatic model_step();
      int       code = int'(op_code);
      bit       acc  = op_valid && model_ready();
      bit       taken;
      int       n_pc = m_pc;
      bit [3:0] n_sr = m_sr;
      bit       n_fl = 1'b0;
      bit       n_tr = m_trapped;
      if (alu_flag_valid) n_sr[2:0] = {alu_carry, alu_sign, alu_zero};
      if (m_flushing) begin
         n_fl = 1'b0;
      end else if (m_trapped) begin
         if (trap_ack) begin
            n_tr = 1'b0; n_fl = 1'b1; n_pc = 'h10;
         end
      end else if (acc) begin
         taken = (code == 2) || (code == 3 && m_sr[0]) || (code == 4 && m_sr[1]) ||
                 (code == 5 && (m_sr[0] || m_sr[1]));
         if (code >= 1 && code <= 7) begin
            if (taken) begin
               n_pc = jmp_pc(int'(target), mode); n_fl = 1'b1;
            end else begin
               n_pc = seq_pc(m_pc, mode);
            end
            if (code == 6) n_sr = imm_sr;
            if (code == 7) n_sr = n_sr ^ imm_sr;
         end else begin
            m_epc = m_pc; m_cause = (code == 0) ? 0 : 1;
            n_sr[3] = 1'b1; n_tr = 1'b1;
         end
      end
      if (alu_issue && !alu_flag_valid && m_pend < 3) m_pend++;
      if (alu_flag_valid && !alu_issue && m_pend > 0) m_pend--;
      m_pc = n_pc; m_sr = n_sr; m_flushing = n_fl; m_trapped = n_tr;
   endtask

   task automatic check_outputs(input string where);
      chk({where, ".pc"}, pc, m_pc);
      chk({where, ".status"}, status, m_sr);
      chk({where, ".flush"}, flush, m_flushing);
      chk({where, ".trap"}, trap, m_trapped);
      chk({where, ".epc"}, epc, m_epc);
      chk({where, ".cause"}, trap_cause, m_cause);
   endtask

   // Check ready outputs, clock once, then check registered outputs.
   task automatic tick();
      #1;
      chk("op_ready", op_ready, model_ready());
      chk("issue_ready", alu_issue_ready, m_pend < 3);
      model_step();
      @(posedge clk);
      #1;
      check_outputs("step");
   endtask

   task automatic idle();
      op_valid = 1'b0; op_code = 4'd1; mode = 1'b1; target = 20'h00000; imm_sr = 4'b0000;
      alu_issue = 1'b0; alu_flag_valid = 1'b0; alu_zero = 1'b0; alu_sign = 1'b0;
      alu_carry = 1'b0; trap_ack = 1'b0;
   endtask

   task automatic do_op(input logic [3:0] code, input logic md, input logic [19:0] tgt,
                        input logic [3:0] imm);
      idle();
      op_valid = 1'b1; op_code = code; mode = md; target = tgt; imm_sr = imm;
      tick();
   endtask

   task automatic async_reset_check(input string where);
      idle();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs(where);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int code;
      rst_n = 1'b0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      repeat (3) do_op(4'd1, 1'b1, 20'h00000, 4'b0000);
      chk("nop3.pc", pc, 20'h00003);

      do_op(4'd2, 1'b1, 20'hFFFFF, 4'b0000);
      idle(); tick();
      do_op(4'd1, 1'b1, 20'h00000, 4'b0000);
      chk("wrap_full.pc", pc, 20'h00000);
      do_op(4'd2, 1'b0, 20'h003FF, 4'b0000);
      idle(); tick();
      do_op(4'd1, 1'b0, 20'h00000, 4'b0000);
      chk("wrap_half.pc", pc, 20'h00000);

      idle(); alu_issue = 1'b1; tick();
      idle(); op_valid = 1'b1; op_code = 4'd3; target = 20'h12345;
      #1; chk("jz_stall.ready", op_ready, 1'b0);
      tick();
      alu_flag_valid = 1'b1; alu_zero = 1'b1;
      tick();
      alu_flag_valid = 1'b0; alu_zero = 1'b0;
      tick();
      chk("jz.pc", pc, 20'h12345);
      chk("jz.flush", flush, 1'b1);
      chk("jz.ready", op_ready, 1'b0);
      idle(); tick();
      chk("jz.flush_done", flush, 1'b0);

      do_op(4'd6, 1'b1, 20'h00000, 4'b0011);
      idle(); op_valid = 1'b1; op_code = 4'd7; imm_sr = 4'b0101;
      alu_flag_valid = 1'b1; alu_carry = 1'b1;
      tick();
      chk("xsr_flags.status", status, 4'b0001);
      idle(); op_valid = 1'b1; op_code = 4'd6; imm_sr = 4'b1010;
      alu_flag_valid = 1'b1; alu_carry = 1'b1;
      tick();
      chk("lsr_flags.status", status, 4'b1010);

      do_op(4'd2, 1'b1, 20'h00040, 4'b0000);
      idle(); tick();
      do_op(4'hB, 1'b1, 20'h00000, 4'b0000);
      chk("illegal.trap", trap, 1'b1);
      chk("illegal.cause", trap_cause, 2'd1);
      chk("illegal.epc", epc, 20'h00040);
      chk("illegal.T", status[3], 1'b1);
      idle(); op_valid = 1'b1;
      tick();
      trap_ack = 1'b1; tick();
      chk("ack.pc", pc, 20'h00010);
      chk("ack.flush", flush, 1'b1);
      idle(); tick();
      do_op(4'd1, 1'b1, 20'h00000, 4'b0000);
      chk("after_trap.pc", pc, 20'h00011);

      do_op(4'd2, 1'b1, 20'h00ABC, 4'b0000);
      async_reset_check("rst_in_flush");
      do_op(4'd0, 1'b1, 20'h00000, 4'b0000);
      chk("trap_op.cause", trap_cause, 2'd0);
      async_reset_check("rst_in_trap");
      idle(); tick();

      for (int i = 0; i < 600; i++) begin
         idle();
         op_valid = ($urandom_range(0, 3) != 0);
         code = int'($urandom_range(0, 15));
         if (code == 0 || code > 7) begin
            if ($urandom_range(0, 7) != 0) code = int'($urandom_range(1, 7));
         end
         op_code = 4'(code);
         mode = 1'($urandom_range(0, 1));
         target = 20'($urandom);
         imm_sr = 4'($urandom);
         alu_issue = (m_pend < 3) && ($urandom_range(0, 2) == 0);
         alu_flag_valid = ($urandom_range(0, 2) == 0);
         if (op_valid && code >= 3 && code <= 5 && m_pend == 0) alu_flag_valid = 1'b0;
         alu_zero = 1'($urandom_range(0, 1));
         alu_sign = 1'($urandom_range(0, 1));
         alu_carry = 1'($urandom_range(0, 1));
         trap_ack = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
